// File: rtl/vend_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vend_pkg : shared states, coin codes and coin decoding.   Rev 1.0
// ----------------------------------------------------------------------------
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      REFUND  = 2'd3
   } state_e;

   localparam logic [1:0] COIN_1   = 2'b00;
   localparam logic [1:0] COIN_2   = 2'b01;
   localparam logic [1:0] COIN_5   = 2'b10;
   localparam logic [1:0] COIN_BAD = 2'b11;

   function automatic logic [3:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_1:  return 4'd1;
         COIN_2:  return 4'd2;
         COIN_5:  return 4'd5;
         default: return 4'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vend_timer : 8-bit loadable down-counter, expire on the final enabled tick. Rev 1.0
// ----------------------------------------------------------------------------
module vend_timer (
   input  logic       clk_i,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic       en_i,
   input  logic [7:0] load_val_i,
   output logic       expire_o
);

   logic [7:0] count_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         count_q <= 8'd0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != 8'd0)) begin
         count_q <= count_q - 8'd1;
      end
   end

   // Flags the tick that takes the count to zero, so N enabled ticks after a load of N.
   assign expire_o = en_i && !load_i && (count_q <= 8'd1);

endmodule
`default_nettype wire

// File: rtl/vend_credit_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vend_credit_ctrl : coin credit accumulation, vend/refund decision, change. Rev 1.0
// ----------------------------------------------------------------------------
module vend_credit_ctrl
   import vend_pkg::*;
#(
   parameter logic [3:0] PRICE          = 4'd10,
   parameter int         DISP_CYCLES    = 2,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic       cancel,
   output logic [3:0] credit,
   output logic       reg_en_n,
   output logic       dispense,
   output logic       change_valid,
   output logic [3:0] change_amt,
   output logic       coin_reject
);

   localparam logic [7:0] C_TIMEOUT   = 8'(TIMEOUT_CYCLES);
   localparam logic [3:0] C_DISP_N    = 4'(DISP_CYCLES);
   localparam logic [3:0] C_DISP_LAST = 4'(DISP_CYCLES - 1);

   state_e     state_q;
   logic [3:0] credit_q;
   logic       reg_en_n_q;
   logic       dispense_q;
   logic       change_valid_q;
   logic [3:0] change_amt_q;
   logic       coin_reject_q;
   logic [3:0] disp_cnt_q;

   logic       coin_ok_d;
   logic       coin_accept_d;
   logic [4:0] sum_d;
   logic [4:0] diff_d;
   logic       tmr_en_d;
   logic       tmr_expire;

   assign coin_ok_d     = coin_valid && (coin_code != COIN_BAD);
   assign coin_accept_d = coin_ok_d &&
                          ((state_q == IDLE) || ((state_q == COLLECT) && !cancel));
   assign sum_d         = {1'b0, credit_q} + {1'b0, coin_value(coin_code)};
   assign diff_d        = sum_d - {1'b0, PRICE};
   assign tmr_en_d      = (state_q == COLLECT) && !coin_accept_d && !cancel;

   vend_timer u_timer (
      .clk_i      (clk),
      .clr_i      (clr),
      .load_i     (coin_accept_d),
      .en_i       (tmr_en_d),
      .load_val_i (C_TIMEOUT),
      .expire_o   (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q        <= IDLE;
         credit_q       <= 4'd0;
         reg_en_n_q     <= 1'b1;
         dispense_q     <= 1'b0;
         change_valid_q <= 1'b0;
         change_amt_q   <= 4'd0;
         coin_reject_q  <= 1'b0;
         disp_cnt_q     <= 4'd0;
      end else begin
         reg_en_n_q     <= 1'b1;
         dispense_q     <= 1'b0;
         change_valid_q <= 1'b0;
         coin_reject_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (coin_ok_d) begin
                  credit_q   <= coin_value(coin_code);
                  reg_en_n_q <= 1'b0;
                  state_q    <= COLLECT;
               end else begin
                  coin_reject_q <= coin_valid;
               end
            end
            COLLECT: begin
               if (cancel) begin
                  coin_reject_q <= coin_valid;
                  change_amt_q  <= credit_q;
                  state_q       <= REFUND;
               end else if (coin_ok_d) begin
                  credit_q   <= sum_d[3:0];
                  reg_en_n_q <= 1'b0;
                  if (sum_d >= {1'b0, PRICE}) begin
                     change_amt_q <= diff_d[3:0];
                     disp_cnt_q   <= 4'd0;
                     state_q      <= VEND;
                  end
               end else begin
                  coin_reject_q <= coin_valid;
                  if (tmr_expire) begin
                     change_amt_q <= credit_q;
                     state_q      <= REFUND;
                  end
               end
            end
            VEND: begin
               coin_reject_q <= coin_valid;
               // Entry cycle has dispense low; DISP_CYCLES high cycles follow, then the clear.
               if (disp_cnt_q != C_DISP_N) begin
                  dispense_q     <= 1'b1;
                  disp_cnt_q     <= disp_cnt_q + 4'd1;
                  change_valid_q <= (disp_cnt_q == C_DISP_LAST) && (change_amt_q != 4'd0);
               end else begin
                  disp_cnt_q <= 4'd0;
                  credit_q   <= 4'd0;
                  reg_en_n_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            REFUND: begin
               coin_reject_q  <= coin_valid;
               change_valid_q <= 1'b1;
               credit_q       <= 4'd0;
               reg_en_n_q     <= 1'b0;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign credit       = credit_q;
   assign reg_en_n     = reg_en_n_q;
   assign dispense     = dispense_q;
   assign change_valid = change_valid_q;
   assign change_amt   = change_amt_q;
   assign coin_reject  = coin_reject_q;

endmodule
`default_nettype wire
